// File: rtl/lbp_img_host.sv
// Host side of the LBP engine memory interface: loads the gray image into the gray SRAM,
// serves engine reads, forwards result writes and reports done/err.
module lbp_img_host #(
  parameter int unsigned IMG_W = 128,
  parameter int unsigned IMG_H = 128,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          img_valid,
  input  logic [7:0]    img_data,
  output logic [AW-1:0] gsram_addr,
  output logic          gsram_we,
  output logic [7:0]    gsram_wdata,
  input  logic [7:0]    gsram_rdata,
  output logic          gray_ready,
  input  logic          gray_req,
  input  logic [AW-1:0] gray_addr,
  output logic [7:0]    gray_data,
  input  logic          lbp_valid,
  input  logic [AW-1:0] lbp_addr,
  input  logic [7:0]    lbp_data,
  output logic [AW-1:0] lsram_addr,
  output logic          lsram_we,
  output logic [7:0]    lsram_wdata,
  input  logic          finish,
  output logic          done,
  output logic          err,
  output logic [AW:0]   lbp_count
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned CW   = $clog2(IMG_W);

  localparam logic [AW:0]    NPIX_W    = (AW+1)'(NPIX);
  localparam logic [AW:0]    EXP_CNT   = (AW+1)'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [AW:0]    CNT_MAX   = '1;
  localparam logic [AW-1:0]  LAST_LOAD = AW'(NPIX - 1);
  localparam logic [AW-1:0]  LAST_ROW  = AW'(IMG_H - 1);
  localparam logic [CW-1:0]  LAST_COL  = CW'(IMG_W - 1);

  localparam logic [1:0] LOAD  = 2'd0;
  localparam logic [1:0] SERVE = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]    state, state_d;
  logic [AW-1:0] load_cnt;
  logic          rd_pend;
  logic [7:0]    hold;

  logic          in_load, in_serve, in_done;
  logic          load_wr, load_last, rd_issue, lbp_wr;
  logic [AW-1:0] row;
  logic [CW-1:0] col;
  logic          border, cnt_sat;
  logic [AW:0]   cnt_next;
  logic          err_set;

  always_comb begin
    in_load  = (state == LOAD);
    in_serve = (state == SERVE);
    in_done  = (state == DONE);
    // Strobes are gated by reset so the SRAMs see no write while reset is held.
    load_wr   = in_load & img_valid & ~reset;
    load_last = load_wr & (load_cnt == LAST_LOAD);
    rd_issue  = in_serve & gray_req;
    lbp_wr    = in_serve & lbp_valid & ~reset;
  end

  always_comb begin
    gsram_we    = load_wr;
    gsram_wdata = img_data;
    gsram_addr  = rd_issue ? gray_addr : load_cnt;
    lsram_we    = lbp_wr;
    lsram_addr  = lbp_addr;
    lsram_wdata = lbp_data;
    gray_data   = rd_pend ? gsram_rdata : hold;
  end

  always_comb begin
    row      = lbp_addr >> CW;
    col      = lbp_addr[CW-1:0];
    border   = (row == '0) | (row >= LAST_ROW) | (col == '0) | (col == LAST_COL);
    cnt_sat  = (lbp_count == CNT_MAX);
    cnt_next = lbp_count + {{AW{1'b0}}, (lbp_wr & ~cnt_sat)};
    err_set  = (in_load & gray_req)
             | (rd_issue & ({1'b0, gray_addr} >= NPIX_W))
             | (lbp_wr & border)
             | (lbp_wr & (cnt_next == CNT_MAX))
             | (in_serve & finish & (cnt_next != EXP_CNT))
             | (in_done & (gray_req | lbp_valid));
  end

  always_comb begin
    state_d = state;
    case (state)
      LOAD:    if (load_last) state_d = SERVE;
      SERVE:   if (finish) state_d = DONE;
      DONE:    state_d = DONE;
      default: state_d = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= LOAD;
      load_cnt   <= '0;
      gray_ready <= 1'b0;
      rd_pend    <= 1'b0;
      hold       <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      lbp_count  <= '0;
    end else begin
      state   <= state_d;
      rd_pend <= rd_issue;
      if (load_wr) load_cnt <= load_cnt + 1'b1;
      if (load_last) begin
        gray_ready <= 1'b1;
      end else if (in_serve & finish) begin
        gray_ready <= 1'b0;
      end
      if (rd_pend) hold <= gsram_rdata;
      if (in_serve & finish) done <= 1'b1;
      if (err_set) err <= 1'b1;
      lbp_count <= cnt_next;
    end
  end

endmodule
